// File: rtl/mips_pkg.sv
// Shared definitions for the MEM stage: access-size codes and the dump FSM state encoding.
package mips_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    DUMP_IDLE = 2'd0,
    DUMP_READ = 2'd1,
    DUMP_SEND = 2'd2,
    DUMP_DONE = 2'd3
  } dump_state_t;

endpackage

// File: rtl/memoria_datos.sv
// Data RAM: one byte-enabled write port, two registered read ports (pipeline and dump).
// Each byte lane is its own array so every lane infers a plain RAM with a single writer.
module memoria_datos
  import mips_pkg::*;
#(
  parameter int NBITS      = 32,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [3:0]            i_wr_be,
  input  logic [DEPTH_LOG2-1:0] i_wr_addr,
  input  logic [NBITS-1:0]      i_wr_data,
  input  logic                  i_rd_a_en,
  input  logic [DEPTH_LOG2-1:0] i_rd_a_addr,
  output logic [NBITS-1:0]      o_rd_a_data,
  input  logic                  i_rd_b_en,
  input  logic [DEPTH_LOG2-1:0] i_rd_b_addr,
  output logic [NBITS-1:0]      o_rd_b_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LANES = 4;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      // Contents start at zero and survive i_reset; only the read registers are cleared.
      logic [7:0] mem_lane [DEPTH] = '{default: 8'h00};
      logic [7:0] rd_a_reg;
      logic [7:0] rd_b_reg;

      always_ff @(posedge i_clk) begin
        if (i_wr_be[gi]) begin
          mem_lane[i_wr_addr] <= i_wr_data[gi*8 +: 8];
        end
      end

      // Reads sample the array before the same-edge write lands (read-before-write).
      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          rd_a_reg <= '0;
          rd_b_reg <= '0;
        end else begin
          if (i_rd_a_en) rd_a_reg <= mem_lane[i_rd_a_addr];
          if (i_rd_b_en) rd_b_reg <= mem_lane[i_rd_b_addr];
        end
      end

      assign o_rd_a_data[gi*8 +: 8] = rd_a_reg;
      assign o_rd_b_data[gi*8 +: 8] = rd_b_reg;
    end
  endgenerate

endmodule

// File: rtl/etapa_mem_datos.sv
// MEM pipeline stage: byte/half/word stores, registered loads, branch resolve and debug memory dump.
// Optional MEM_ALIGN_CHECK_EN enables misaligned-access suppression and the sticky error flag.
module etapa_mem_datos
  import mips_pkg::*;
#(
  parameter int NBITS      = 32,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_Step,
  input  logic [NBITS-1:0] i_ALU,
  input  logic [NBITS-1:0] i_Registro2,
  input  logic             i_MemWrite,
  input  logic             i_MemRead,
  input  logic [1:0]       i_TamanoFiltro,
  input  logic             i_Branch,
  input  logic             i_NBranch,
  input  logic             i_Cero,
  input  logic [NBITS-1:0] i_PCBranch,
  input  logic             i_DumpStart,
  input  logic             i_DumpReady,
  output logic [NBITS-1:0] o_ReadData,
  output logic             o_PCSrc,
  output logic [NBITS-1:0] o_PCBranch,
  output logic [NBITS-1:0] o_DumpData,
  output logic             o_DumpValid,
  output logic             o_DumpDone,
  output logic             o_MisalignErr
);

  localparam int                    DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] LAST_IDX = DEPTH_LOG2'(DEPTH - 1);

  logic [DEPTH_LOG2-1:0] word_idx;
  logic [1:0]            byte_off;
  logic [3:0]            lane_be;
  logic [3:0]            wr_be;
  logic [NBITS-1:0]      lane_wdata;
  logic                  misalign;
  logic                  unused_addr_bits;

  assign word_idx         = i_ALU[DEPTH_LOG2+1:2];
  assign byte_off         = i_ALU[1:0];
  assign unused_addr_bits = ^i_ALU[NBITS-1:DEPTH_LOG2+2];

  assign o_PCSrc    = (i_Branch & i_Cero) | (i_NBranch & ~i_Cero);
  assign o_PCBranch = i_PCBranch;

  // Store data is replicated across lanes so the byte enables alone pick the destination.
  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = i_Registro2;
    case (i_TamanoFiltro)
      SZ_BYTE: begin
        lane_be    = 4'b0001 << byte_off;
        lane_wdata = {4{i_Registro2[7:0]}};
      end
      SZ_HALF: begin
        lane_be    = byte_off[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{i_Registro2[15:0]}};
      end
      default: begin
        lane_be    = 4'b1111;
        lane_wdata = i_Registro2;
      end
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic misalign_err_reg;

  always_comb begin
    misalign = 1'b0;
    case (i_TamanoFiltro)
      SZ_BYTE: misalign = 1'b0;
      SZ_HALF: misalign = byte_off[0];
      default: misalign = |byte_off;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      misalign_err_reg <= 1'b0;
    end else if (i_Step && (i_MemWrite || i_MemRead) && misalign) begin
      misalign_err_reg <= 1'b1;
    end
  end

  assign o_MisalignErr = misalign_err_reg;
`else
  assign misalign      = 1'b0;
  assign o_MisalignErr = 1'b0;
`endif

  assign wr_be = (i_Step && i_MemWrite && !misalign) ? lane_be : 4'b0000;

  // Dump FSM
  dump_state_t           state_reg, state_next;
  logic [DEPTH_LOG2-1:0] cnt_reg, cnt_next;
  logic                  valid_reg, valid_next;
  logic                  done_reg, done_next;
  logic                  dump_rd_en;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg <= DUMP_IDLE;
      cnt_reg   <= '0;
      valid_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      valid_reg <= valid_next;
      done_reg  <= done_next;
    end
  end

  // A running pipeline (i_Step=1) always pre-empts the dump.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    valid_next = valid_reg;
    done_next  = done_reg;
    dump_rd_en = 1'b0;
    case (state_reg)
      DUMP_IDLE: begin
        if (i_DumpStart && !i_Step) begin
          state_next = DUMP_READ;
          cnt_next   = '0;
          done_next  = 1'b0;
        end
      end
      DUMP_READ: begin
        if (i_Step) begin
          state_next = DUMP_IDLE;
          valid_next = 1'b0;
        end else begin
          state_next = DUMP_SEND;
          valid_next = 1'b1;
          dump_rd_en = 1'b1;
        end
      end
      DUMP_SEND: begin
        if (i_Step) begin
          state_next = DUMP_IDLE;
          valid_next = 1'b0;
        end else if (i_DumpReady) begin
          valid_next = 1'b0;
          if (cnt_reg == LAST_IDX) begin
            state_next = DUMP_DONE;
          end else begin
            cnt_next   = cnt_reg + DEPTH_LOG2'(1);
            state_next = DUMP_READ;
          end
        end
      end
      DUMP_DONE: begin
        done_next  = 1'b1;
        state_next = DUMP_IDLE;
      end
      default: state_next = DUMP_IDLE;
    endcase
  end

  assign o_DumpValid = valid_reg;
  assign o_DumpDone  = done_reg;

  memoria_datos #(
    .NBITS      (NBITS),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_memoria_datos (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_wr_be     (wr_be),
    .i_wr_addr   (word_idx),
    .i_wr_data   (lane_wdata),
    .i_rd_a_en   (i_Step & i_MemRead),
    .i_rd_a_addr (word_idx),
    .o_rd_a_data (o_ReadData),
    .i_rd_b_en   (dump_rd_en),
    .i_rd_b_addr (cnt_reg),
    .o_rd_b_data (o_DumpData)
  );

endmodule

// File: tb/tb_etapa_mem_datos.sv
// Randomized self-checking bench for etapa_mem_datos against a byte-addressed reference memory.
// Build with MEM_ALIGN_CHECK_EN defined to exercise the alignment checker.
module tb_etapa_mem_datos;

  localparam int NBITS      = 32;
  localparam int DEPTH_LOG2 = 5;
  localparam int DEPTH      = 32;
  localparam int NBYTES     = 128;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_Step = 1'b0;
  logic [31:0] i_ALU = '0;
  logic [31:0] i_Registro2 = '0;
  logic        i_MemWrite = 1'b0;
  logic        i_MemRead = 1'b0;
  logic [1:0]  i_TamanoFiltro = '0;
  logic        i_Branch = 1'b0;
  logic        i_NBranch = 1'b0;
  logic        i_Cero = 1'b0;
  logic [31:0] i_PCBranch = '0;
  logic        i_DumpStart = 1'b0;
  logic        i_DumpReady = 1'b0;
  logic [31:0] o_ReadData;
  logic        o_PCSrc;
  logic [31:0] o_PCBranch;
  logic [31:0] o_DumpData;
  logic        o_DumpValid;
  logic        o_DumpDone;
  logic        o_MisalignErr;

  etapa_mem_datos #(
    .NBITS      (NBITS),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_Step         (i_Step),
    .i_ALU          (i_ALU),
    .i_Registro2    (i_Registro2),
    .i_MemWrite     (i_MemWrite),
    .i_MemRead      (i_MemRead),
    .i_TamanoFiltro (i_TamanoFiltro),
    .i_Branch       (i_Branch),
    .i_NBranch      (i_NBranch),
    .i_Cero         (i_Cero),
    .i_PCBranch     (i_PCBranch),
    .i_DumpStart    (i_DumpStart),
    .i_DumpReady    (i_DumpReady),
    .o_ReadData     (o_ReadData),
    .o_PCSrc        (o_PCSrc),
    .o_PCBranch     (o_PCBranch),
    .o_DumpData     (o_DumpData),
    .o_DumpValid    (o_DumpValid),
    .o_DumpDone     (o_DumpDone),
    .o_MisalignErr  (o_MisalignErr)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: little-endian byte array plus the expected registered outputs.
  logic [7:0]  ref_mem [NBYTES];
  logic [31:0] ref_rd;
  logic        ref_err;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] addr);
    int b;
    b = int'(addr[6:2]) * 4;
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  function automatic bit ref_misaligned(input logic [1:0] size, input logic [31:0] addr);
`ifdef MEM_ALIGN_CHECK_EN
    if (size == 2'b00) return 1'b0;
    if (size == 2'b01) return addr[0];
    return addr[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  // One pipeline cycle: drive, clock, update model, compare.
  task automatic mem_op(input string tag, input bit step, input bit we, input bit re,
                        input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data);
    int n;
    logic [31:0] base;
    bit mis;
    i_Step = step; i_MemWrite = we; i_MemRead = re;
    i_TamanoFiltro = size; i_ALU = addr; i_Registro2 = data;
    @(posedge i_clk);
    mis = ref_misaligned(size, addr);
    if (step && re) ref_rd = ref_word(addr);
    if (step && (we || re) && mis) ref_err = 1'b1;
    if (step && we && !mis) begin
      case (size)
        2'b00:   n = 1;
        2'b01:   n = 2;
        default: n = 4;
      endcase
      base = addr & ~32'(n - 1);
      for (int k = 0; k < n; k++) ref_mem[(int'(base[6:0]) + k) % NBYTES] = data[8*k +: 8];
    end
    #1;
    $display("%s step=%0d we=%0d re=%0d sz=%0d addr=%08h data=%08h rd=%08h err=%0d",
             tag, step, we, re, size, addr, data, o_ReadData, o_MisalignErr);
    check_eq({tag, "_rd"}, o_ReadData, ref_rd);
    check_eq({tag, "_err"}, {31'b0, o_MisalignErr}, {31'b0, ref_err});
    i_MemWrite = 1'b0; i_MemRead = 1'b0;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    ref_rd = '0; ref_err = 1'b0;
    $display("reset");
    check_eq("rst_rd", o_ReadData, 32'h0);
    check_eq("rst_dump_data", o_DumpData, 32'h0);
    check_eq("rst_dump_valid", {31'b0, o_DumpValid}, 32'h0);
    check_eq("rst_dump_done", {31'b0, o_DumpDone}, 32'h0);
    check_eq("rst_err", {31'b0, o_MisalignErr}, 32'h0);
  endtask

  // Streams a dump; optional stall, abort (i_Step) or reset at a given beat (-1 = never).
  task automatic run_dump(input int stall_at, input int abort_at, input int reset_at);
    int beat = 0;
    int cycles = 0;
    int stall_left = 5;
    bit waiting = 0;
    bit stopped = 0;
    i_Step = 1'b0; i_MemRead = 1'b0; i_MemWrite = 1'b0; i_DumpReady = 1'b0;
    i_DumpStart = 1'b1;
    @(posedge i_clk); #1;
    i_DumpStart = 1'b0;
    check_eq("dump_start_done_clr", {31'b0, o_DumpDone}, 32'h0);
    while (beat < DEPTH && cycles < 1000 && !stopped) begin
      if (waiting) begin
        check_eq("dump_hold_valid", {31'b0, o_DumpValid}, 32'h1);
        check_eq("dump_hold_data", o_DumpData, ref_word(32'(beat * 4)));
      end
      waiting = 0;
      i_DumpReady = 1'b0;
      if (o_DumpValid) begin
        if (beat == abort_at) begin
          i_Step = 1'b1; stopped = 1;
        end else if (beat == reset_at) begin
          i_reset = 1'b1; stopped = 1;
        end else if (beat == stall_at && stall_left > 0) begin
          stall_left--; waiting = 1;
        end else begin
          i_DumpReady = 1'b1;
          $display("dump beat=%0d data=%08h", beat, o_DumpData);
          check_eq("dump_data", o_DumpData, ref_word(32'(beat * 4)));
          beat++;
        end
      end
      @(posedge i_clk); #1;
      cycles++;
    end
    i_DumpReady = 1'b0;
    if (abort_at >= 0) begin
      check_eq("abort_valid", {31'b0, o_DumpValid}, 32'h0);
      check_eq("abort_done", {31'b0, o_DumpDone}, 32'h0);
      @(posedge i_clk); #1;
      i_Step = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(posedge i_clk); #1;
        check_eq("abort_idle_valid", {31'b0, o_DumpValid}, 32'h0);
      end
    end else if (reset_at >= 0) begin
      i_reset = 1'b0;
      ref_rd = '0; ref_err = 1'b0;
      check_eq("middump_rst_valid", {31'b0, o_DumpValid}, 32'h0);
      check_eq("middump_rst_data", o_DumpData, 32'h0);
      check_eq("middump_rst_done", {31'b0, o_DumpDone}, 32'h0);
      check_eq("middump_rst_rd", o_ReadData, 32'h0);
    end else begin
      check_eq("dump_beats", 32'(beat), 32'(DEPTH));
      for (int i = 0; i < 4 && !o_DumpDone; i++) begin
        @(posedge i_clk); #1;
      end
      check_eq("dump_done", {31'b0, o_DumpDone}, 32'h1);
      check_eq("dump_done_valid", {31'b0, o_DumpValid}, 32'h0);
    end
  endtask

  initial begin
    for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;
    ref_rd = '0; ref_err = 1'b0;
    @(posedge i_clk); #1;
    do_reset();

    // Directed stores/loads
    mem_op("st_word", 1, 1, 0, 2'b10, 32'h8, 32'hDEADBEEF);
    mem_op("ld_word", 1, 0, 1, 2'b10, 32'h8, 32'h0);
    check_eq("ld_word_const", o_ReadData, 32'hDEADBEEF);
    mem_op("st_byte", 1, 1, 0, 2'b00, 32'h9, 32'h000000AA);
    mem_op("ld_byte", 1, 0, 1, 2'b10, 32'h8, 32'h0);
    check_eq("ld_byte_const", o_ReadData, 32'hDEADAAEF);
    mem_op("st_half", 1, 1, 0, 2'b01, 32'hA, 32'h00001234);
    mem_op("ld_half", 1, 0, 1, 2'b10, 32'h8, 32'h0);
    check_eq("ld_half_const", o_ReadData, 32'h1234AAEF);
    mem_op("rbw", 1, 1, 1, 2'b10, 32'h8, 32'hCAFEF00D);
    check_eq("rbw_old_const", o_ReadData, 32'h1234AAEF);
    mem_op("wrap", 1, 0, 1, 2'b10, 32'h0000_1088, 32'h0);
    check_eq("wrap_const", o_ReadData, 32'hCAFEF00D);

    // Misaligned word store
    mem_op("st_mis", 1, 1, 0, 2'b10, 32'h6, 32'h55667788);
    mem_op("ld_mis", 1, 0, 1, 2'b10, 32'h4, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
    check_eq("mis_mem_const", o_ReadData, 32'h0);
    check_eq("mis_err_const", {31'b0, o_MisalignErr}, 32'h1);
    do_reset();
`else
    check_eq("mis_mem_const", o_ReadData, 32'h55667788);
`endif

    // Branch resolution
    for (int i = 0; i < 16; i++) begin
      logic [31:0] tgt;
      bit taken;
      {i_Branch, i_NBranch, i_Cero} = 3'($urandom_range(0, 7));
      tgt = $urandom;
      i_PCBranch = tgt;
      #1;
      taken = (i_Branch && i_Cero) || (i_NBranch && !i_Cero);
      $display("branch b=%0d nb=%0d z=%0d pcsrc=%0d", i_Branch, i_NBranch, i_Cero, o_PCSrc);
      check_eq("pcsrc", {31'b0, o_PCSrc}, {31'b0, taken});
      check_eq("pcbranch", o_PCBranch, tgt);
    end
    i_Branch = 1'b0; i_NBranch = 1'b0; i_Cero = 1'b0;

    // Random pipeline traffic
    for (int i = 0; i < 300; i++) begin
      mem_op("rnd", $urandom_range(0, 9) != 0, 1'($urandom), 1'($urandom),
             2'($urandom_range(0, 3)), $urandom, $urandom);
    end

    // Start while stepping is ignored
    i_Step = 1'b1; i_DumpStart = 1'b1;
    @(posedge i_clk); #1;
    i_DumpStart = 1'b0;
    i_Step = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge i_clk); #1;
      check_eq("start_ignored_valid", {31'b0, o_DumpValid}, 32'h0);
    end

    run_dump(7, -1, -1);
    run_dump(-1, 10, -1);
    run_dump(-1, -1, 5);

    // Memory survives reset
    for (int i = 0; i < 4; i++) mem_op("post_rst_ld", 1, 0, 1, 2'b10, $urandom, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
